// File: rtl/breakpoint_unit_if.sv
// Bus between the breakpoint unit and the front panel / halt controller.
// The master drives the PC, the fetch strobe, the panel switches and the buttons. The slave returns the hit status and the slot LEDs.
interface breakpoint_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_SLOTS  = 2
);
    logic [ADDR_WIDTH-1:0] i_pc;
    logic                  i_fetchN;
    logic                  i_breakpointEnableN;
    logic [ADDR_WIDTH-1:0] i_swAddr;
    logic                  i_swSlot;
    logic                  i_btnSet;
    logic                  i_btnClear;
    logic                  i_btnContinue;
    logic                  o_breakpointHitN;
    logic                  o_hitSlot;
    logic [NUM_SLOTS-1:0]  o_slotValid;

    modport master (
        output i_pc, i_fetchN, i_breakpointEnableN, i_swAddr, i_swSlot,
               i_btnSet, i_btnClear, i_btnContinue,
        input  o_breakpointHitN, o_hitSlot, o_slotValid
    );

    modport slave (
        input  i_pc, i_fetchN, i_breakpointEnableN, i_swAddr, i_swSlot,
               i_btnSet, i_btnClear, i_btnContinue,
        output o_breakpointHitN, o_hitSlot, o_slotValid
    );
endinterface

// File: rtl/breakpoint_unit.sv
// Two-slot PC breakpoint comparator with a latched, active-low hit.
// A Continue press releases the hit and skips exactly one fetch so the halted instruction can run.
module breakpoint_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_SLOTS  = 2
) (
    input logic              i_clk,
    input logic              i_resetn,
    breakpoint_unit_if.slave bus
);
    typedef enum logic [1:0] {ARMED, HIT, SKIP} stateT;

    stateT                 state, stateNext;
    logic [2:0]            setSync, clearSync, continueSync;
    logic                  setEvent, clearEvent, continueEvent;
    logic [ADDR_WIDTH-1:0] holdAddr;
    logic                  holdSlot;
    logic [ADDR_WIDTH-1:0] slotAddr [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  slotValid;
    logic                  hitSlot;
    logic                  anyMatch, matchSlot, loadHitSlot, fetch;

    // Each button goes through two synchronizer flops and a delay flop, which yields one event per press.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            setSync      <= '0;
            clearSync    <= '0;
            continueSync <= '0;
        end else begin
            setSync      <= {setSync[1:0], bus.i_btnSet};
            clearSync    <= {clearSync[1:0], bus.i_btnClear};
            continueSync <= {continueSync[1:0], bus.i_btnContinue};
        end
    end

    assign setEvent      = setSync[1] & ~setSync[2];
    assign clearEvent    = clearSync[1] & ~clearSync[2];
    assign continueEvent = continueSync[1] & ~continueSync[2];
    assign fetch         = ~bus.i_fetchN;

    // Clear empties every slot. A Set in the same cycle then re-arms only the selected slot.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            holdAddr  <= '0;
            holdSlot  <= 1'b0;
            slotValid <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slotAddr[i] <= '0;
            end
        end else begin
            holdAddr <= bus.i_swAddr;
            holdSlot <= bus.i_swSlot;
            if (clearEvent) begin
                slotValid <= '0;
            end
            if (setEvent) begin
                slotAddr[holdSlot]  <= holdAddr;
                slotValid[holdSlot] <= 1'b1;
            end
        end
    end

    // The loop runs downward so that the lowest matching slot index wins.
    always_comb begin
        anyMatch  = 1'b0;
        matchSlot = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slotValid[i] && (slotAddr[i] == bus.i_pc)) begin
                anyMatch  = 1'b1;
                matchSlot = 1'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state   <= ARMED;
            hitSlot <= 1'b0;
        end else begin
            state <= stateNext;
            if (loadHitSlot) begin
                hitSlot <= matchSlot;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        loadHitSlot = 1'b0;
        case (state)
            ARMED: begin
                if (clearEvent) begin
                    stateNext = ARMED;
                end else if (fetch && !bus.i_breakpointEnableN && anyMatch) begin
                    stateNext   = HIT;
                    loadHitSlot = 1'b1;
                end
            end
            HIT: begin
                if (clearEvent || bus.i_breakpointEnableN) begin
                    stateNext = ARMED;
                end else if (continueEvent) begin
                    stateNext = SKIP;
                end
            end
            SKIP: begin
                if (clearEvent || fetch) begin
                    stateNext = ARMED;
                end
            end
            default: stateNext = ARMED;
        endcase
    end

    assign bus.o_breakpointHitN = (state != HIT);
    assign bus.o_hitSlot        = hitSlot;
    assign bus.o_slotValid      = slotValid;
endmodule

// File: tb/tb_breakpoint_unit.sv
// Directed bench for breakpoint_unit with hand-computed expectations.
module tb_breakpoint_unit;
    logic clock;
    logic resetn;
    int   compared;
    int   mismatched;

    breakpoint_unit_if #(.ADDR_WIDTH(16), .NUM_SLOTS(2)) bus ();

    breakpoint_unit #(.ADDR_WIDTH(16), .NUM_SLOTS(2)) dut (
        .i_clk    (clock),
        .i_resetn (resetn),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] pc, input logic fetchN, input logic enableN,
                                 input logic [15:0] swAddr, input logic swSlot, input logic [2:0] buttons);
        bus.i_pc                = pc;
        bus.i_fetchN            = fetchN;
        bus.i_breakpointEnableN = enableN;
        bus.i_swAddr            = swAddr;
        bus.i_swSlot            = swSlot;
        bus.i_btnSet            = buttons[0];
        bus.i_btnClear          = buttons[1];
        bus.i_btnContinue       = buttons[2];
    endtask

    task automatic checkOutput(input string tag, input logic expHitN, input logic expHitSlot,
                               input logic [1:0] expValid);
        compared++;
        assert (bus.o_breakpointHitN === expHitN) else begin
            mismatched++;
            $error("[TB] FAIL %s hitN: observed %b expected %b", tag, bus.o_breakpointHitN, expHitN);
        end
        compared++;
        assert (bus.o_hitSlot === expHitSlot) else begin
            mismatched++;
            $error("[TB] FAIL %s hitSlot: observed %b expected %b", tag, bus.o_hitSlot, expHitSlot);
        end
        compared++;
        assert (bus.o_slotValid === expValid) else begin
            mismatched++;
            $error("[TB] FAIL %s slotValid: observed %b expected %b", tag, bus.o_slotValid, expValid);
        end
    endtask

    task automatic doFetch(input logic [15:0] pc);
        bus.i_pc     = pc;
        bus.i_fetchN = 1'b0;
        tick();
        bus.i_fetchN = 1'b1;
    endtask

    // The button mask is {continue, clear, set}. The event lands on the third edge after the press.
    task automatic pressButtons(input logic [2:0] buttons);
        bus.i_btnSet      = buttons[0];
        bus.i_btnClear    = buttons[1];
        bus.i_btnContinue = buttons[2];
        repeat (3) tick();
    endtask

    task automatic releaseButtons();
        bus.i_btnSet      = 1'b0;
        bus.i_btnClear    = 1'b0;
        bus.i_btnContinue = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        resetn     = 1'b0;
        applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'b000);
        repeat (2) tick();
        checkOutput("reset", 1'b1, 1'b0, 2'b00);
        resetn = 1'b1;

        doFetch(16'h0000);
        checkOutput("noValidSlot", 1'b1, 1'b0, 2'b00);

        bus.i_swAddr = 16'h0123;
        bus.i_swSlot = 1'b0;
        bus.i_btnSet = 1'b1;
        repeat (2) tick();
        checkOutput("setTwoEdges", 1'b1, 1'b0, 2'b00);
        tick();
        checkOutput("setThreeEdges", 1'b1, 1'b0, 2'b01);
        releaseButtons();

        doFetch(16'h0122);
        checkOutput("pcOffByOne", 1'b1, 1'b0, 2'b01);
        doFetch(16'h0123);
        checkOutput("hitSlot0", 1'b0, 1'b0, 2'b01);
        doFetch(16'h0123);
        checkOutput("fetchWhileHit", 1'b0, 1'b0, 2'b01);

        pressButtons(3'b100);
        checkOutput("continue", 1'b1, 1'b0, 2'b01);
        doFetch(16'h0123);
        checkOutput("skipConsumed", 1'b1, 1'b0, 2'b01);
        doFetch(16'h0123);
        checkOutput("hitAfterSkip", 1'b0, 1'b0, 2'b01);
        repeat (3) tick();
        checkOutput("heldContinue", 1'b0, 1'b0, 2'b01);
        releaseButtons();
        checkOutput("releaseContinue", 1'b0, 1'b0, 2'b01);

        pressButtons(3'b100);
        releaseButtons();
        doFetch(16'h5555);
        checkOutput("skipCleared", 1'b1, 1'b0, 2'b01);

        bus.i_swAddr = 16'h0040;
        bus.i_swSlot = 1'b1;
        pressButtons(3'b001);
        releaseButtons();
        checkOutput("setSlot1", 1'b1, 1'b0, 2'b11);
        doFetch(16'h0040);
        checkOutput("hitSlot1", 1'b0, 1'b1, 2'b11);

        pressButtons(3'b100);
        releaseButtons();
        doFetch(16'h5555);
        checkOutput("hitSlotHeld", 1'b1, 1'b1, 2'b11);

        bus.i_swSlot = 1'b0;
        pressButtons(3'b001);
        releaseButtons();
        doFetch(16'h0040);
        checkOutput("bothMatch", 1'b0, 1'b0, 2'b11);
        doFetch(16'h0040);
        checkOutput("bothMatchHold", 1'b0, 1'b0, 2'b11);

        bus.i_breakpointEnableN = 1'b1;
        tick();
        checkOutput("enableRelease", 1'b1, 1'b0, 2'b11);
        doFetch(16'h0040);
        checkOutput("disabledFetch", 1'b1, 1'b0, 2'b11);
        bus.i_breakpointEnableN = 1'b0;
        doFetch(16'h0040);
        checkOutput("noSkipAfterRelease", 1'b0, 1'b0, 2'b11);

        bus.i_swAddr = 16'hBEEF;
        bus.i_swSlot = 1'b1;
        pressButtons(3'b011);
        checkOutput("setAndClear", 1'b1, 1'b0, 2'b10);
        releaseButtons();

        pressButtons(3'b100);
        releaseButtons();
        doFetch(16'hBEEF);
        checkOutput("continueIgnored", 1'b0, 1'b1, 2'b10);

        resetn = 1'b0;
        tick();
        checkOutput("resetMidHit", 1'b1, 1'b0, 2'b00);
        resetn = 1'b1;
        doFetch(16'hBEEF);
        checkOutput("afterReset", 1'b1, 1'b0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/breakpoint_unit.md
Name: breakpoint_unit

Overview:
- Produces the active-low breakpoint-hit signal that the clock/halt controller consumes in run mode.
- Holds two user-programmed breakpoint addresses, loaded from front-panel switches and buttons, and compares them against the PC on every fetch strobe.
- Latches a hit until the user presses Continue. It then suppresses exactly one comparison, so the halted instruction can execute without re-triggering.

Parameters:
- ADDR_WIDTH, 16, width of PC and breakpoint addresses
- NUM_SLOTS, 2, number of breakpoint slots (fixed at 2; slot select is 1 bit)

Ports:
- i_clk  input  1  system clock; all logic on rising edge
- i_resetn  input  1  synchronous reset, active-low
- i_pc  input  ADDR_WIDTH  current program counter, valid when i_fetchN=0
- i_fetchN  input  1  active-low, one cycle per instruction fetch
- i_breakpointEnableN  input  1  active-low global enable (from clock block)
- i_swAddr  input  ADDR_WIDTH  address switches
- i_swSlot  input  1  slot select for Set
- i_btnSet  input  1  set button, 1 = closed
- i_btnClear  input  1  clear-all button, 1 = closed
- i_btnContinue  input  1  continue button, 1 = closed
- o_breakpointHitN  output  1  active-low latched hit, to clock block
- o_hitSlot  output  1  slot that caused the current hit
- o_slotValid  output  2  per-slot armed flags (LEDs)

Behaviour:
- Reset (i_resetn=0 at a clock edge):
  - slot addresses = 0, o_slotValid = 00, o_breakpointHitN = 1, o_hitSlot = 0.
  - skip flag = 0; all sync/edge registers = 0.
  - Reset mid-hit releases the hit in the same edge.
- Button handling:
  - Each button passes through a 2-flop synchronizer plus a third delay flop.
  - Event = sync2 & ~sync3: exactly one cycle per press, 3 edges after the button closes.
  - Holding a button generates no further events.
- Address capture:
  - i_swAddr and i_swSlot are registered once into a holding register every cycle.
  - A Set event writes the holding register into the selected slot address and sets that slot's valid bit.
- Clear event:
  - o_slotValid <= 00, o_breakpointHitN <= 1, skip <= 0. Addresses are retained.
  - Set and Clear events in the same cycle: Clear applies first, then Set. Result: only the selected slot is valid.
- Compare (1-cycle latency):
  - Condition on an edge: i_fetchN=0, i_breakpointEnableN=0, o_breakpointHitN=1, skip=0, and at least one valid slot with address == i_pc.
  - Next edge: o_breakpointHitN <= 0; o_hitSlot <= lowest matching slot index (slot 0 wins when both match).
  - Exact-equality compare over the full ADDR_WIDTH; no wrap or masking.
- Skip flag:
  - Any fetch strobe while skip=1 clears skip and performs no comparison, regardless of enable.
- Hit latch:
  - While o_breakpointHitN=0, fetch strobes are ignored.
  - o_hitSlot holds its value.
  - Set events are still accepted and do not alter the hit.
- Continue event:
  - Only effective while o_breakpointHitN=0. Then o_breakpointHitN <= 1 and skip <= 1.
  - Ignored otherwise; skip is unchanged.
- Enable release:
  - If i_breakpointEnableN=1 while a hit is latched, o_breakpointHitN <= 1 on the next edge, and skip is not set.
- States, encoded by o_breakpointHitN and skip:
  - ARMED (1,0): ARMED->HIT on match.
  - HIT (0,x): HIT->SKIP on Continue; HIT->ARMED on Clear or enable release.
  - SKIP (1,1): SKIP->ARMED on the next fetch strobe or on Clear.

Test Plan:
- Reset → hitN=1, slotValid=00, hitSlot=0. Fetch with pc=0x0000 and no valid slot → no hit.
- Load slot0=0x0123 (swSlot=0, press Set) → slotValid=01 three edges after press. Fetch pc=0x0122 → no hit. Fetch pc=0x0123 → hitN=0 one cycle later, hitSlot=0.
- Load both slots=0x0040. Fetch pc=0x0040 → hitSlot=0. Further fetch strobes while hit → no change.
- Continue during hit → hitN=1. Next fetch pc=0x0123 → no hit (skip consumed). Following fetch pc=0x0123 → hit again.
- Hit latched, then set i_breakpointEnableN=1 → hitN=1 next edge. With enable high, fetch of a matching pc → no hit.
- Set and Clear in the same cycle with swSlot=1, swAddr=0xBEEF → slotValid=10, slot1=0xBEEF. Continue pressed with no hit → ignored (next matching fetch still hits).
